// File: rtl/divu_seq_if.sv
// Client command/result port and IBUS initiator signals of divu_seq.
// master is the sequencer's view; slave is the client/bus-responder view.
interface divu_seq_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_DIV64;
  logic [31:0] CMD_DVSR;
  logic [31:0] CMD_DVDNTH;
  logic [31:0] CMD_DVDNTL;
  logic        RES_VALID;
  logic [31:0] RES_Q;
  logic [31:0] RES_R;
  logic        RES_OVF;
  logic        RES_ERR;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;

  modport master (
    input  CMD_VALID, CMD_DIV64, CMD_DVSR, CMD_DVDNTH, CMD_DVDNTL, IBUS_DI, IBUS_BUSY,
    output CMD_READY, RES_VALID, RES_Q, RES_R, RES_OVF, RES_ERR,
           IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );

  modport slave (
    output CMD_VALID, CMD_DIV64, CMD_DVSR, CMD_DVDNTH, CMD_DVDNTL, IBUS_DI, IBUS_BUSY,
    input  CMD_READY, RES_VALID, RES_Q, RES_R, RES_OVF, RES_ERR,
           IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );
endinterface

// File: rtl/divu_seq.sv
// Runs one signed divide on the DIVU register block over IBUS: write operands, read DVCR/remainder/quotient, clear OVF.
// Each access is issue / wait-while-BUSY / one idle cycle; a per-access busy counter aborts a stuck responder.
module divu_seq #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       CE_F,
  input  logic       RES_N,
  divu_seq_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] A_DVSR   = 32'hFFFF_FF00;
  localparam logic [31:0] A_DVDNT  = 32'hFFFF_FF04;
  localparam logic [31:0] A_DVCR   = 32'hFFFF_FF08;
  localparam logic [31:0] A_DVDNTH = 32'hFFFF_FF10;
  localparam logic [31:0] A_DVDNTL = 32'hFFFF_FF14;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVSR, S_WR_DVDNTH, S_WR_DVDNT, S_RD_DVCR, S_RD_REM, S_RD_QUO, S_CLR_OVF, S_DONE
  } state_t;
  typedef enum logic [1:0] {PH_GAP, PH_ISSUE, PH_WAIT} phase_t;

  state_t           r_state;
  phase_t           r_ph;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div64;
  logic [31:0]      r_dvsr, r_dvdnth, r_dvdntl;
  logic             r_cmd_rdy, r_res_vld, r_ovf, r_err;
  logic [31:0]      r_q, r_r;
  logic             r_req, r_we;
  logic [31:0]      r_a, r_do;
  logic [31:0]      w_a, w_do;
  logic             w_we;
  state_t           w_next;
  logic             w_unused_ce_f;

  assign w_unused_ce_f = CE_F;

  // Bus fields for the access that belongs to the current state
  always_comb begin
    w_a  = A_DVSR;
    w_do = r_dvsr;
    w_we = 1'b1;
    case (r_state)
      S_WR_DVDNTH: begin w_a = A_DVDNTH; w_do = r_dvdnth; end
      S_WR_DVDNT:  begin w_a = r_div64 ? A_DVDNTL : A_DVDNT; w_do = r_dvdntl; end
      S_RD_DVCR:   begin w_a = A_DVCR;   w_do = 32'h0; w_we = 1'b0; end
      S_RD_REM:    begin w_a = A_DVDNTH; w_do = 32'h0; w_we = 1'b0; end
      S_RD_QUO:    begin w_a = A_DVDNTL; w_do = 32'h0; w_we = 1'b0; end
      S_CLR_OVF:   begin w_a = A_DVCR;   w_do = 32'h0; end
      default: ;
    endcase
  end

  always_comb begin
    w_next = S_DONE;
    case (r_state)
      S_WR_DVSR:   w_next = r_div64 ? S_WR_DVDNTH : S_WR_DVDNT;
      S_WR_DVDNTH: w_next = S_WR_DVDNT;
      S_WR_DVDNT:  w_next = S_RD_DVCR;
      S_RD_DVCR:   w_next = S_RD_REM;
      S_RD_REM:    w_next = S_RD_QUO;
      S_RD_QUO:    w_next = r_ovf ? S_CLR_OVF : S_DONE;
      default:     w_next = S_DONE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;    r_ph <= PH_GAP;       r_cnt <= '0;
      r_div64 <= 1'b0;      r_dvsr <= 32'h0;      r_dvdnth <= 32'h0;  r_dvdntl <= 32'h0;
      r_cmd_rdy <= 1'b1;    r_res_vld <= 1'b0;    r_ovf <= 1'b0;      r_err <= 1'b0;
      r_q <= 32'h0;         r_r <= 32'h0;
      r_req <= 1'b0;        r_we <= 1'b0;         r_a <= 32'h0;       r_do <= 32'h0;
    end else if (CE_R) begin
      if (!RES_N) begin
        r_state <= S_IDLE;  r_ph <= PH_GAP;       r_cnt <= '0;
        r_cmd_rdy <= 1'b1;  r_res_vld <= 1'b0;    r_ovf <= 1'b0;      r_err <= 1'b0;
        r_q <= 32'h0;       r_r <= 32'h0;
        r_req <= 1'b0;      r_we <= 1'b0;         r_a <= 32'h0;       r_do <= 32'h0;
      end else begin
        r_res_vld <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (bus.CMD_VALID) begin
              r_div64   <= bus.CMD_DIV64;
              r_dvsr    <= bus.CMD_DVSR;
              r_dvdnth  <= bus.CMD_DVDNTH;
              r_dvdntl  <= bus.CMD_DVDNTL;
              r_cmd_rdy <= 1'b0;
              r_ovf <= 1'b0;  r_err <= 1'b0;  r_q <= 32'h0;  r_r <= 32'h0;
              // First write is issued straight from the command to save a cycle
              r_state <= S_WR_DVSR;  r_ph <= PH_ISSUE;  r_cnt <= '0;
              r_req <= 1'b1;  r_we <= 1'b1;  r_a <= A_DVSR;  r_do <= bus.CMD_DVSR;
            end
          end
          S_DONE: begin
            if (r_ph == PH_GAP) begin
              r_res_vld <= 1'b1;
              r_ph      <= PH_ISSUE;
            end else begin
              r_state   <= S_IDLE;
              r_ph      <= PH_GAP;
              r_cmd_rdy <= 1'b1;
            end
          end
          default: begin
            case (r_ph)
              PH_GAP: begin
                r_req <= 1'b1;  r_we <= w_we;  r_a <= w_a;  r_do <= w_do;
                r_cnt <= '0;    r_ph <= PH_ISSUE;
              end
              PH_ISSUE: r_ph <= PH_WAIT;
              default: begin
                if (!bus.IBUS_BUSY) begin
                  r_req <= 1'b0;  r_we <= 1'b0;  r_ph <= PH_GAP;  r_state <= w_next;
                  if (r_state == S_RD_DVCR) r_ovf <= bus.IBUS_DI[0];
                  if (r_state == S_RD_REM)  r_r   <= bus.IBUS_DI;
                  if (r_state == S_RD_QUO)  r_q   <= bus.IBUS_DI;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  r_req <= 1'b0;  r_we <= 1'b0;  r_ph <= PH_GAP;  r_state <= S_DONE;
                  r_err <= 1'b1;  r_ovf <= 1'b0; r_q <= 32'h0;    r_r <= 32'h0;
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  assign bus.CMD_READY = r_cmd_rdy;
  assign bus.RES_VALID = r_res_vld;
  assign bus.RES_Q     = r_q;
  assign bus.RES_R     = r_r;
  assign bus.RES_OVF   = r_ovf;
  assign bus.RES_ERR   = r_err;
  assign bus.IBUS_A    = r_a;
  assign bus.IBUS_DO   = r_do;
  assign bus.IBUS_BA   = 4'hF;
  assign bus.IBUS_WE   = r_we;
  assign bus.IBUS_REQ  = r_req;
endmodule

// File: tb/tb_divu_seq.sv
// Bench for divu_seq: a DIVU register-block responder on IBUS plus an arithmetic reference for the client results.
module tb_divu_seq;
  localparam int TIMEOUT_CYC = 63;

  logic CLK = 1'b0;
  logic RST_N, CE_R, CE_F, RES_N;
  divu_seq_if bus();

  divu_seq #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] a; logic we; logic [31:0] d;} acc_t;
  acc_t trace[$];
  acc_t cur;
  logic [31:0] d_dvsr, d_h, d_l, d_dvcr;
  bit in_acc, stuck, gate, a_changed, gap_bad;
  int age, wleft, low_run, wait_dvcr, wait_rand_max, busy_samples, req_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Signed divide as the DIVU defines it; saturates on overflow or zero divisor
  function automatic void ref_div(input bit div64, input logic [31:0] dvsr, input logic [31:0] h,
                                  input logic [31:0] l, output logic [31:0] q, output logic [31:0] r,
                                  output bit ovf);
    longint dvd, dv, qq, rr;
    dvd = div64 ? $signed({h, l}) : $signed({{32{l[31]}}, l});
    dv  = $signed({{32{dvsr[31]}}, dvsr});
    ovf = (dv == 0) || (dvd == 64'sh8000_0000_0000_0000 && dv == -1);
    qq = 0; rr = 0;
    if (!ovf) begin
      qq = dvd / dv;
      rr = dvd % dv;
      ovf = (qq > 64'sd2147483647) || (qq < -64'sd2147483648);
    end
    if (ovf) begin
      q = ((dvd < 0) != (dv < 0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r = 32'h0;
    end else begin
      q = qq[31:0];
      r = rr[31:0];
    end
  endfunction

  task automatic apply_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q, r;
    bit ovf;
    case (a)
      32'hFFFF_FF00: d_dvsr = d;
      32'hFFFF_FF04: begin ref_div(1'b0, d_dvsr, 32'h0, d, q, r, ovf); d_l = q; d_h = r; if (ovf) d_dvcr[0] = 1'b1; end
      32'hFFFF_FF08: d_dvcr = d;
      32'hFFFF_FF10: d_h = d;
      32'hFFFF_FF14: begin ref_div(1'b1, d_dvsr, d_h, d, q, r, ovf); d_l = q; d_h = r; if (ovf) d_dvcr[0] = 1'b1; end
      default: ;
    endcase
  endtask

  // IBUS responder and CE_R generator; acts only on negedges that follow an active edge
  initial begin
    CE_R = 1'b1; bus.IBUS_BUSY = 1'b0; bus.IBUS_DI = 32'h0;
    d_dvsr = 0; d_h = 0; d_l = 0; d_dvcr = 0;
    in_acc = 0; age = 0; wleft = 0; low_run = 1;
    forever begin
      @(negedge CLK);
      if (CE_R && RST_N) begin
        if (bus.IBUS_REQ && !in_acc) begin
          if (trace.size() > 0 && low_run != 1) gap_bad = 1;
          in_acc = 1; age = 1; req_cycles++;
          cur.a = bus.IBUS_A; cur.we = bus.IBUS_WE; cur.d = bus.IBUS_DO;
          trace.push_back(cur);
          if (stuck && trace.size() == 1) wleft = 1000;
          else if (!bus.IBUS_WE && bus.IBUS_A == 32'hFFFF_FF08) wleft = wait_dvcr;
          else wleft = $urandom_range(wait_rand_max, 0);
          bus.IBUS_BUSY = (wleft > 0);
          case (bus.IBUS_A)
            32'hFFFF_FF08: bus.IBUS_DI = d_dvcr;
            32'hFFFF_FF10: bus.IBUS_DI = d_h;
            32'hFFFF_FF14: bus.IBUS_DI = d_l;
            default:       bus.IBUS_DI = 32'hDEAD_BEEF;
          endcase
        end else if (bus.IBUS_REQ) begin
          req_cycles++;
          if (bus.IBUS_A !== cur.a || bus.IBUS_WE !== cur.we || bus.IBUS_DO !== cur.d) a_changed = 1;
          if (age >= 2) begin wleft--; busy_samples++; bus.IBUS_BUSY = (wleft > 0); end
          age++;
        end else if (in_acc) begin
          if (!bus.IBUS_BUSY && cur.we) apply_write(cur.a, cur.d);
          in_acc = 0; bus.IBUS_BUSY = 1'b0; low_run = 1;
        end else begin
          low_run++;
        end
      end
      CE_R = gate ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
  end

  task automatic run_cmd(input string tag, input bit div64, input logic [31:0] dvsr, input logic [31:0] h,
                         input logic [31:0] l, input int wdvcr, input int wmax, input bit stk, input bit gt,
                         output logic [31:0] oq, output logic [31:0] orr, output logic oovf);
    logic [31:0] eq, er;
    bit eovf, got;
    int lat, exp_lat;
    logic [31:0] ea[$];
    logic        ew[$];
    logic [31:0] ed[$];
    ref_div(div64, dvsr, h, l, eq, er, eovf);
    ea.push_back(32'hFFFF_FF00); ew.push_back(1); ed.push_back(dvsr);
    if (stk) begin
      eq = 32'h0; er = 32'h0; eovf = 0;
    end else begin
      if (div64) begin ea.push_back(32'hFFFF_FF10); ew.push_back(1); ed.push_back(h); end
      ea.push_back(div64 ? 32'hFFFF_FF14 : 32'hFFFF_FF04); ew.push_back(1); ed.push_back(l);
      ea.push_back(32'hFFFF_FF08); ew.push_back(0); ed.push_back(32'h0);
      ea.push_back(32'hFFFF_FF10); ew.push_back(0); ed.push_back(32'h0);
      ea.push_back(32'hFFFF_FF14); ew.push_back(0); ed.push_back(32'h0);
      if (eovf) begin ea.push_back(32'hFFFF_FF08); ew.push_back(1); ed.push_back(32'h0); end
    end
    wait_dvcr = wdvcr; wait_rand_max = wmax; stuck = stk; gate = gt;
    for (int i = 0; i < 200 && !bus.CMD_READY; i++) @(negedge CLK);
    trace.delete(); busy_samples = 0; req_cycles = 0; a_changed = 0; gap_bad = 0;
    chk({tag, "_ready"}, 32'(bus.CMD_READY), 32'h1);
    bus.CMD_VALID = 1'b1; bus.CMD_DIV64 = div64;
    bus.CMD_DVSR = dvsr; bus.CMD_DVDNTH = h; bus.CMD_DVDNTL = l;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (!bus.CMD_READY) got = 1;
    end
    bus.CMD_VALID = 1'b0;
    chk({tag, "_accept"}, 32'(got), 32'h1);
    lat = 1; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (bus.RES_VALID) got = 1;
      else begin @(negedge CLK); lat++; end
    end
    chk({tag, "_res_valid"}, 32'(got), 32'h1);
    oq = bus.RES_Q; orr = bus.RES_R; oovf = bus.RES_OVF;
    chk({tag, "_q"}, bus.RES_Q, eq);
    chk({tag, "_r"}, bus.RES_R, er);
    chk({tag, "_ovf"}, 32'(bus.RES_OVF), 32'(eovf));
    chk({tag, "_err"}, 32'(bus.RES_ERR), 32'(stk));
    chk({tag, "_hold"}, 32'(a_changed), 32'h0);
    chk({tag, "_gap"}, 32'(gap_bad), 32'h0);
    chk({tag, "_ba"}, 32'(bus.IBUS_BA), 32'hF);
    if (stk) chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(TIMEOUT_CYC + 1));
    if (!gt && !stk) begin
      exp_lat = 16 + (div64 ? 3 : 0) + (eovf ? 3 : 0) + busy_samples;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    end
    chk({tag, "_n_acc"}, 32'(trace.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < trace.size(); i++) begin
      chk({tag, $sformatf("_a%0d", i)}, trace[i].a, ea[i]);
      chk({tag, $sformatf("_we%0d", i)}, 32'(trace[i].we), 32'(ew[i]));
      if (ew[i]) chk({tag, $sformatf("_do%0d", i)}, trace[i].d, ed[i]);
    end
    if (!gt) begin
      @(negedge CLK);
      chk({tag, "_strobe_1cyc"}, 32'(bus.RES_VALID), 32'h0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, h, l, dv;
    logic ovf;
    bit got, d64;
    RST_N = 1'b0; RES_N = 1'b1; CE_F = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_DIV64 = 1'b0;
    bus.CMD_DVSR = 32'h0; bus.CMD_DVDNTH = 32'h0; bus.CMD_DVDNTL = 32'h0;
    stuck = 0; gate = 0; wait_dvcr = 0; wait_rand_max = 0;
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'h1);
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'h0);
    chk("rst_res_q", bus.RES_Q, 32'h0);
    chk("rst_res_r", bus.RES_R, 32'h0);
    chk("rst_res_ovf", 32'(bus.RES_OVF), 32'h0);
    chk("rst_res_err", 32'(bus.RES_ERR), 32'h0);
    chk("rst_req", 32'(bus.IBUS_REQ), 32'h0);
    chk("rst_we", 32'(bus.IBUS_WE), 32'h0);
    chk("rst_a", bus.IBUS_A, 32'h0);
    chk("rst_do", bus.IBUS_DO, 32'h0);
    chk("rst_ba", 32'(bus.IBUS_BA), 32'hF);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    run_cmd("d32", 0, 32'd7, 32'h1234_5678, 32'd100, 39, 0, 0, 0, q, r, ovf);
    chk("d32_q_const", q, 32'h0000_000E);
    chk("d32_r_const", r, 32'h0000_0002);
    run_cmd("d32s", 0, 32'd7, 32'h0, 32'hFFFF_FF9C, 39, 0, 0, 0, q, r, ovf);
    chk("d32s_q_const", q, 32'hFFFF_FFF2);
    chk("d32s_r_const", r, 32'hFFFF_FFFE);
    run_cmd("d64", 1, 32'h10, 32'h1, 32'h0, 39, 0, 0, 0, q, r, ovf);
    chk("d64_q_const", q, 32'h1000_0000);
    chk("d64_r_const", r, 32'h0);
    run_cmd("dz", 0, 32'h0, 32'h0, 32'd5, 39, 0, 0, 0, q, r, ovf);
    chk("dz_q_const", q, 32'h7FFF_FFFF);
    chk("dz_ovf_const", 32'(ovf), 32'h1);
    run_cmd("after_ovf", 0, 32'd3, 32'h0, 32'd10, 5, 0, 0, 0, q, r, ovf);
    run_cmd("stuck", 0, 32'd9, 32'h0, 32'd81, 0, 0, 1, 0, q, r, ovf);
    run_cmd("post_stuck", 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FF00, 10, 2, 0, 0, q, r, ovf);

    // Soft reset while the divide is stalling the DVCR read
    stuck = 0; gate = 0; wait_dvcr = 39; wait_rand_max = 0;
    for (int i = 0; i < 200 && !bus.CMD_READY; i++) @(negedge CLK);
    bus.CMD_VALID = 1'b1; bus.CMD_DIV64 = 1'b0; bus.CMD_DVSR = 32'd5; bus.CMD_DVDNTL = 32'd50;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (bus.IBUS_REQ && !bus.IBUS_WE && bus.IBUS_A == 32'hFFFF_FF08) got = 1;
    end
    chk("sr_reach_dvcr", 32'(got), 32'h1);
    repeat (5) @(negedge CLK);
    RES_N = 1'b0;
    @(negedge CLK);
    RES_N = 1'b1;
    chk("sr_req", 32'(bus.IBUS_REQ), 32'h0);
    chk("sr_ready", 32'(bus.CMD_READY), 32'h1);
    chk("sr_valid", 32'(bus.RES_VALID), 32'h0);
    got = 0;
    repeat (60) begin
      @(negedge CLK);
      if (bus.RES_VALID || bus.IBUS_REQ) got = 1;
    end
    chk("sr_quiet", 32'(got), 32'h0);
    run_cmd("post_sr", 0, 32'd6, 32'h0, 32'd45, 39, 1, 0, 0, q, r, ovf);

    for (int n = 0; n < 24; n++) begin
      d64 = 1'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0:       h = $urandom;
        1:       h = 32'hFFFF_FFFF;
        default: h = 32'h0;
      endcase
      l  = $urandom;
      dv = ($urandom_range(7, 0) == 0) ? 32'h0 :
           ($urandom_range(1, 0) == 0) ? 32'($urandom_range(1000, 1)) : $urandom;
      run_cmd($sformatf("rnd%0d", n), d64, dv, h, l, $urandom_range(45, 0), $urandom_range(3, 0),
              0, (n % 4) == 3, q, r, ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
